// File: rtl/mc_ctrl_pkg.sv
// Shared opcodes, state encodings and datapath select codes for the multi-cycle MIPS control FSM.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEM_ADDR = 4'd2,
      ST_MEM_RD   = 4'd3,
      ST_MEM_WB   = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_EXEC_R   = 4'd6,
      ST_R_WB     = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_JUMP     = 4'd9,
      ST_EXEC_I   = 4'd10,
      ST_I_WB     = 4'd11,
      ST_TRAP     = 4'd15
   } state_t;

   localparam logic [2:0] ALU_OP_ADD   = 3'b000;
   localparam logic [2:0] ALU_OP_SUB   = 3'b001;
   localparam logic [2:0] ALU_OP_FUNCT = 3'b010;
   localparam logic [2:0] ALU_OP_SLT   = 3'b011;

   localparam logic [1:0] ALUSRCB_B      = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that wait on the memory handshake and run the timeout counter.
   function automatic logic is_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_ctrl_out_dec.sv
// Combinational control-output decode: state plus opcode/zero/ready qualifiers to datapath controls.
module mc_ctrl_out_dec
   import mc_ctrl_pkg::*;
(
   input  logic       rst_i,
   input  state_t     state_i,
   input  logic [5:0] instr_op_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       i_or_d_o,
   output logic       reg_write_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [1:0] pc_source_o,
   output logic       retire_o,
   output logic       trap_o
);

   always_comb begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      i_or_d_o     = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = ALUSRCB_B;
      alu_op_o     = ALU_OP_ADD;
      pc_source_o  = PCSRC_ALU;
      retire_o     = 1'b0;
      trap_o       = 1'b0;
      // Reset gates everything combinationally so a write in flight is cut immediately.
      if (!rst_i) begin
         case (state_i)
            ST_FETCH: begin
               mem_read_o  = 1'b1;
               alu_src_b_o = ALUSRCB_FOUR;
               pc_write_o  = mem_ready_i;
               ir_write_o  = mem_ready_i;
            end
            ST_DECODE:   alu_src_b_o = ALUSRCB_IMM_SH;
            ST_MEM_ADDR: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = ALUSRCB_IMM;
            end
            ST_MEM_RD: begin
               mem_read_o = 1'b1;
               i_or_d_o   = 1'b1;
            end
            ST_MEM_WB: begin
               reg_write_o  = 1'b1;
               mem_to_reg_o = 1'b1;
               retire_o     = 1'b1;
            end
            ST_MEM_WR: begin
               mem_write_o = 1'b1;
               i_or_d_o    = 1'b1;
               retire_o    = mem_ready_i;
            end
            ST_EXEC_R: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = ALU_OP_FUNCT;
            end
            ST_R_WB: begin
               reg_write_o = 1'b1;
               reg_dst_o   = 1'b1;
               retire_o    = 1'b1;
            end
            ST_EXEC_I: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = ALUSRCB_IMM;
               alu_op_o    = (instr_op_i == OP_SLTI) ? ALU_OP_SLT : ALU_OP_ADD;
            end
            ST_I_WB: begin
               reg_write_o = 1'b1;
               retire_o    = 1'b1;
            end
            ST_BRANCH: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = ALU_OP_SUB;
               pc_source_o = PCSRC_ALUOUT;
               pc_write_o  = (instr_op_i == OP_BEQ) ? zero_i : !zero_i;
               retire_o    = 1'b1;
            end
            ST_JUMP: begin
               pc_source_o = PCSRC_JUMP;
               pc_write_o  = 1'b1;
               retire_o    = 1'b1;
            end
            ST_TRAP:     trap_o = 1'b1;
            default:     trap_o = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: state register, next-state sequencing and memory wait timeout.
//  state     | meaning
//  FETCH     | read instruction at PC, PC+4 into PC when memory ready
//  DECODE    | branch target into ALUOut, dispatch on opcode
//  MEM_ADDR  | A + sext(imm) address for lw/sw
//  MEM_RD    | load read, wait for memory
//  MEM_WB    | MDR into rt, retire
//  MEM_WR    | store write, retire when memory ready
//  EXEC_R    | R-type ALU operation
//  R_WB      | ALUOut into rd, retire
//  BRANCH    | compare A-B, conditional PC load, retire
//  JUMP      | jump target into PC, retire
//  EXEC_I    | addi/slti ALU operation
//  I_WB      | ALUOut into rt, retire
//  TRAP      | illegal opcode or memory timeout, held until reset
module multicycle_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] instr_op_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       i_or_d_o,
   output logic       reg_write_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [1:0] pc_source_o,
   output logic       retire_o,
   output logic       trap_o,
   output logic [3:0] state_o
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_expired;

   // Expiry means this idle cycle is the TIMEOUT-th; a ready in the same cycle still wins.
   assign wait_expired = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ST_FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (state_next != state)
            wait_cnt <= '0;
         else if (is_wait_state(state) && !mem_ready_i)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH: begin
            if (mem_ready_i)       state_next = ST_DECODE;
            else if (wait_expired) state_next = ST_TRAP;
         end
         ST_DECODE: begin
            case (instr_op_i)
               OP_R:             state_next = ST_EXEC_R;
               OP_ADDI, OP_SLTI: state_next = ST_EXEC_I;
               OP_LW, OP_SW:     state_next = ST_MEM_ADDR;
               OP_BEQ, OP_BNE:   state_next = ST_BRANCH;
               OP_J:             state_next = ST_JUMP;
               default:          state_next = ST_TRAP;
            endcase
         end
         ST_MEM_ADDR: state_next = (instr_op_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD: begin
            if (mem_ready_i)       state_next = ST_MEM_WB;
            else if (wait_expired) state_next = ST_TRAP;
         end
         ST_MEM_WR: begin
            if (mem_ready_i)       state_next = ST_FETCH;
            else if (wait_expired) state_next = ST_TRAP;
         end
         ST_EXEC_R: state_next = ST_R_WB;
         ST_EXEC_I: state_next = ST_I_WB;
         ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: state_next = ST_FETCH;
         ST_TRAP:   state_next = ST_TRAP;
         default:   state_next = ST_TRAP;
      endcase
   end

   assign state_o = state;

   mc_ctrl_out_dec u_out_dec (
      .rst_i        (rst_i),
      .state_i      (state),
      .instr_op_i   (instr_op_i),
      .zero_i       (zero_i),
      .mem_ready_i  (mem_ready_i),
      .pc_write_o   (pc_write_o),
      .ir_write_o   (ir_write_o),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .i_or_d_o     (i_or_d_o),
      .reg_write_o  (reg_write_o),
      .reg_dst_o    (reg_dst_o),
      .mem_to_reg_o (mem_to_reg_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .pc_source_o  (pc_source_o),
      .retire_o     (retire_o),
      .trap_o       (trap_o)
   );

endmodule
